// File: rtl/mbus_rx_msg_buffer_pkg.sv
// Shared types and constants for the MBus receive message buffer.
//   AddrWidth / DataWidth : MBus address and data word widths.
//   rx_state_e            : handshake FSM states.
//   sat_inc8              : saturating 8-bit increment for the abort counter.
package mbus_rx_msg_buffer_pkg;

  localparam int unsigned AddrWidth = 8;
  localparam int unsigned DataWidth = 32;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAck    = 2'd1,
    StWaitLo = 2'd2,
    StHold   = 2'd3
  } rx_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/mbus_sync2.sv
// Generic two-flop synchronizer for a single-bit level signal.
//   clk_i  : destination clock
//   rst_ni : asynchronous active-low reset (output resets to 0)
//   d_i    : asynchronous input
//   q_o    : synchronized output, two clk_i cycles of latency
module mbus_sync2 (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/mbus_rx_msg_buffer.sv
// Receive-side message buffer between the MBus wrapper RX port and the layer controller.
// Completes the RX_REQ/RX_ACK four-phase handshake, queues a multi-word message in an
// inline FIFO and presents it as one framed message.
//   CLKIN, RESETn            : clock, asynchronous active-low reset
//   RX_ADDR/DATA/PEND/BROADCAST, RX_REQ, RX_FAIL, RX_ACK : wrapper RX port
//   MSG_VALID/ADDR/BCAST/LEN/OVF, MSG_CLR : framed message status and release
//   RD_EN, RD_DATA, RD_EMPTY : word read-out (RD_DATA registered)
//   FAIL_CNT                 : saturating count of RX_FAIL aborts
module mbus_rx_msg_buffer
  import mbus_rx_msg_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned LEN_W = $clog2(DEPTH) + 1
) (
  input  logic                 CLKIN,
  input  logic                 RESETn,
  input  logic [AddrWidth-1:0] RX_ADDR,
  input  logic [DataWidth-1:0] RX_DATA,
  input  logic                 RX_REQ,
  input  logic                 RX_PEND,
  input  logic                 RX_BROADCAST,
  input  logic                 RX_FAIL,
  output logic                 RX_ACK,
  output logic                 MSG_VALID,
  output logic [AddrWidth-1:0] MSG_ADDR,
  output logic                 MSG_BCAST,
  output logic [LEN_W-1:0]     MSG_LEN,
  output logic                 MSG_OVF,
  input  logic                 RD_EN,
  output logic [DataWidth-1:0] RD_DATA,
  output logic                 RD_EMPTY,
  input  logic                 MSG_CLR,
  output logic [7:0]           FAIL_CNT
);

  localparam int unsigned Aw   = $clog2(DEPTH);
  localparam int unsigned PtrW = Aw + 1;

  logic req_s, fail_s;

  mbus_sync2 u_sync_req (
    .clk_i  (CLKIN),
    .rst_ni (RESETn),
    .d_i    (RX_REQ),
    .q_o    (req_s)
  );

  mbus_sync2 u_sync_fail (
    .clk_i  (CLKIN),
    .rst_ni (RESETn),
    .d_i    (RX_FAIL),
    .q_o    (fail_s)
  );

  rx_state_e            state_q, state_d;
  logic                 pend_q, pend_d;
  logic                 first_q, first_d;
  logic                 valid_q, valid_d;
  logic                 ovf_q, ovf_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic                 bcast_q, bcast_d;
  logic [7:0]           cnt_q, cnt_d;
  logic                 fail_s_q;
  logic                 blk_q, blk_d;
  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [DataWidth-1:0] rd_data_q, rd_data_d;
  logic [DataWidth-1:0] mem_q [DEPTH];

  logic push, pop, flush, empty, full, fail_hit;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PtrW-1] != rd_ptr_q[PtrW-1]) &&
                 (wr_ptr_q[Aw-1:0] == rd_ptr_q[Aw-1:0]);

  // A held-high fail_s keeps flushing, but only its rising edge counts as a new abort.
  assign fail_hit = fail_s && (state_q != StHold);

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    first_d = first_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    len_d   = len_q;
    addr_d  = addr_q;
    bcast_d = bcast_q;
    cnt_d   = cnt_q;
    blk_d   = blk_q;
    push    = 1'b0;
    flush   = 1'b0;

    // After an abort, a request still high is not a new word until it has dropped.
    if (!req_s) blk_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req_s && !blk_q) begin
          if (!first_q) begin
            addr_d  = RX_ADDR;
            bcast_d = RX_BROADCAST;
            first_d = 1'b1;
          end
          if (!full) begin
            push  = 1'b1;
            len_d = len_q + LEN_W'(1);
          end else begin
            ovf_d = 1'b1;
          end
          pend_d  = RX_PEND;
          state_d = StAck;
        end
      end
      StAck: begin
        if (!req_s) begin
          state_d = StWaitLo;
          // Raised here so MSG_VALID rises on the same edge that RX_ACK falls.
          if (!pend_q) valid_d = 1'b1;
        end
      end
      StWaitLo: begin
        state_d = pend_q ? StIdle : StHold;
      end
      StHold: begin
        if (MSG_CLR) begin
          flush   = 1'b1;
          valid_d = 1'b0;
          ovf_d   = 1'b0;
          len_d   = '0;
          first_d = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Abort overrides any capture decided above.
    if (fail_hit) begin
      push    = 1'b0;
      flush   = 1'b1;
      valid_d = 1'b0;
      ovf_d   = 1'b0;
      len_d   = '0;
      first_d = 1'b0;
      pend_d  = 1'b0;
      addr_d  = addr_q;
      bcast_d = bcast_q;
      blk_d   = 1'b1;
      state_d = StIdle;
      if (!fail_s_q) cnt_d = sat_inc8(cnt_q);
    end
  end

  // Read path: a flush in the same cycle suppresses the pop.
  always_comb begin
    pop       = RD_EN && !empty && !flush;
    rd_data_d = pop ? mem_q[rd_ptr_q[Aw-1:0]] : rd_data_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    end
  end

  always_ff @(posedge CLKIN or negedge RESETn) begin
    if (!RESETn) begin
      state_q   <= StIdle;
      pend_q    <= 1'b0;
      first_q   <= 1'b0;
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
      len_q     <= '0;
      addr_q    <= '0;
      bcast_q   <= 1'b0;
      cnt_q     <= '0;
      fail_s_q  <= 1'b0;
      blk_q     <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      first_q   <= first_d;
      valid_q   <= valid_d;
      ovf_q     <= ovf_d;
      len_q     <= len_d;
      addr_q    <= addr_d;
      bcast_q   <= bcast_d;
      cnt_q     <= cnt_d;
      fail_s_q  <= fail_s;
      blk_q     <= blk_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Storage array needs no reset; the pointers define what is valid.
  always_ff @(posedge CLKIN) begin
    if (push) mem_q[wr_ptr_q[Aw-1:0]] <= RX_DATA;
  end

  assign RX_ACK    = (state_q == StAck);
  assign MSG_VALID = valid_q;
  assign MSG_ADDR  = addr_q;
  assign MSG_BCAST = bcast_q;
  assign MSG_LEN   = len_q;
  assign MSG_OVF   = ovf_q;
  assign RD_DATA   = rd_data_q;
  assign RD_EMPTY  = empty;
  assign FAIL_CNT  = cnt_q;

endmodule

// File: tb/tb_mbus_rx_msg_buffer.sv
// Directed self-checking bench for mbus_rx_msg_buffer (DEPTH = 8).
module tb_mbus_rx_msg_buffer;

  logic        clk = 1'b0;
  logic        RESETn;
  logic [7:0]  RX_ADDR;
  logic [31:0] RX_DATA;
  logic        RX_REQ, RX_PEND, RX_BROADCAST, RX_FAIL;
  logic        RX_ACK, MSG_VALID, MSG_BCAST, MSG_OVF, RD_EN, RD_EMPTY, MSG_CLR;
  logic [7:0]  MSG_ADDR;
  logic [3:0]  MSG_LEN;
  logic [31:0] RD_DATA;
  logic [7:0]  FAIL_CNT;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mbus_rx_msg_buffer #(
    .DEPTH (8),
    .LEN_W (4)
  ) dut (
    .CLKIN        (clk),
    .RESETn       (RESETn),
    .RX_ADDR      (RX_ADDR),
    .RX_DATA      (RX_DATA),
    .RX_REQ       (RX_REQ),
    .RX_PEND      (RX_PEND),
    .RX_BROADCAST (RX_BROADCAST),
    .RX_FAIL      (RX_FAIL),
    .RX_ACK       (RX_ACK),
    .MSG_VALID    (MSG_VALID),
    .MSG_ADDR     (MSG_ADDR),
    .MSG_BCAST    (MSG_BCAST),
    .MSG_LEN      (MSG_LEN),
    .MSG_OVF      (MSG_OVF),
    .RD_EN        (RD_EN),
    .RD_DATA      (RD_DATA),
    .RD_EMPTY     (RD_EMPTY),
    .MSG_CLR      (MSG_CLR),
    .FAIL_CNT     (FAIL_CNT)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Full four-phase handshake for one word; returns edge counts to ACK rise and fall.
  task automatic send_word(input logic [7:0] a, input logic [31:0] d, input logic p,
                           input logic b, output int rise_n, output int fall_n);
    @(negedge clk);
    RX_ADDR = a; RX_DATA = d; RX_PEND = p; RX_BROADCAST = b; RX_REQ = 1'b1;
    rise_n = 0;
    do begin @(posedge clk); #1; rise_n++; end while (!RX_ACK && rise_n < 20);
    @(negedge clk);
    RX_REQ = 1'b0;
    fall_n = 0;
    do begin @(posedge clk); #1; fall_n++; end while (RX_ACK && fall_n < 20);
  endtask

  task automatic rd_word(output logic [31:0] d);
    @(negedge clk); RD_EN = 1'b1;
    @(posedge clk); #1; RD_EN = 1'b0;
    d = RD_DATA;
  endtask

  task automatic msg_clear();
    @(negedge clk); MSG_CLR = 1'b1;
    @(posedge clk); #1; MSG_CLR = 1'b0;
  endtask

  task automatic pulse_fail();
    @(negedge clk); RX_FAIL = 1'b1;
    @(negedge clk); RX_FAIL = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset_vals(input string pfx);
    check_eq({pfx, "_ack"},   64'(RX_ACK),    64'd0);
    check_eq({pfx, "_valid"}, 64'(MSG_VALID), 64'd0);
    check_eq({pfx, "_addr"},  64'(MSG_ADDR),  64'd0);
    check_eq({pfx, "_bcast"}, 64'(MSG_BCAST), 64'd0);
    check_eq({pfx, "_len"},   64'(MSG_LEN),   64'd0);
    check_eq({pfx, "_ovf"},   64'(MSG_OVF),   64'd0);
    check_eq({pfx, "_rdata"}, 64'(RD_DATA),   64'd0);
    check_eq({pfx, "_empty"}, 64'(RD_EMPTY),  64'd1);
    check_eq({pfx, "_fcnt"},  64'(FAIL_CNT),  64'd0);
  endtask

  initial begin
    int r, f, acked, n;
    logic [31:0] d;
    logic seen;

    RX_ADDR = '0; RX_DATA = '0; RX_REQ = 1'b0; RX_PEND = 1'b0; RX_BROADCAST = 1'b0;
    RX_FAIL = 1'b0; RD_EN = 1'b0; MSG_CLR = 1'b0;
    RESETn = 1'b1;
    #2 RESETn = 1'b0;
    #10;
    check_reset_vals("rst");
    @(negedge clk); RESETn = 1'b1;
    repeat (2) @(negedge clk);

    // Single word
    send_word(8'hA5, 32'hDEADBEEF, 1'b0, 1'b0, r, f);
    check_eq("single_ack_rise", 64'(r), 64'd3);
    check_eq("single_ack_fall", 64'(f), 64'd3);
    check_eq("single_valid_same_edge", 64'(MSG_VALID), 64'd1);
    check_eq("single_addr", 64'(MSG_ADDR), 64'hA5);
    check_eq("single_len", 64'(MSG_LEN), 64'd1);
    check_eq("single_not_empty", 64'(RD_EMPTY), 64'd0);
    rd_word(d);
    check_eq("single_rdata", 64'(d), 64'hDEADBEEF);
    check_eq("single_empty_after", 64'(RD_EMPTY), 64'd1);
    msg_clear();
    check_eq("clr_valid", 64'(MSG_VALID), 64'd0);
    check_eq("clr_len", 64'(MSG_LEN), 64'd0);

    // Four-word broadcast message, address taken from the first word only
    for (int i = 1; i <= 4; i++)
      send_word(8'h0F + 8'(i), 32'(i), (i != 4), (i == 1), r, f);
    check_eq("four_valid", 64'(MSG_VALID), 64'd1);
    check_eq("four_len", 64'(MSG_LEN), 64'd4);
    check_eq("four_bcast", 64'(MSG_BCAST), 64'd1);
    check_eq("four_addr", 64'(MSG_ADDR), 64'h10);
    for (int i = 1; i <= 4; i++) begin
      rd_word(d);
      check_eq($sformatf("four_rd%0d", i), 64'(d), 64'(i));
    end
    msg_clear();

    // Ten words into an 8-deep FIFO
    acked = 0;
    for (int i = 1; i <= 10; i++) begin
      send_word(8'h30, 32'(i), (i != 10), 1'b0, r, f);
      if (r < 20 && f < 20) acked++;
    end
    check_eq("ovf_acked", 64'(acked), 64'd10);
    check_eq("ovf_flag", 64'(MSG_OVF), 64'd1);
    check_eq("ovf_len", 64'(MSG_LEN), 64'd8);
    check_eq("ovf_valid", 64'(MSG_VALID), 64'd1);
    for (int i = 1; i <= 8; i++) begin
      rd_word(d);
      check_eq($sformatf("ovf_rd%0d", i), 64'(d), 64'(i));
    end
    check_eq("ovf_empty", 64'(RD_EMPTY), 64'd1);
    rd_word(d);
    check_eq("ovf_rd_empty_hold", 64'(d), 64'd8);
    msg_clear();
    check_eq("ovf_clr", 64'(MSG_OVF), 64'd0);

    // Abort after two words
    send_word(8'h40, 32'hAAAA0001, 1'b1, 1'b0, r, f);
    send_word(8'h40, 32'hAAAA0002, 1'b1, 1'b0, r, f);
    check_eq("fail_pre_len", 64'(MSG_LEN), 64'd2);
    pulse_fail();
    repeat (3) @(negedge clk);
    check_eq("fail_empty", 64'(RD_EMPTY), 64'd1);
    check_eq("fail_valid", 64'(MSG_VALID), 64'd0);
    check_eq("fail_len", 64'(MSG_LEN), 64'd0);
    check_eq("fail_cnt1", 64'(FAIL_CNT), 64'd1);
    send_word(8'h41, 32'h00000055, 1'b0, 1'b0, r, f);
    check_eq("after_fail_valid", 64'(MSG_VALID), 64'd1);
    check_eq("after_fail_len", 64'(MSG_LEN), 64'd1);
    check_eq("after_fail_addr", 64'(MSG_ADDR), 64'h41);
    rd_word(d);
    check_eq("after_fail_rd", 64'(d), 64'h55);
    msg_clear();

    // Request held off in HOLD; MSG_CLR beats RD_EN
    send_word(8'h21, 32'h00000011, 1'b1, 1'b0, r, f);
    send_word(8'h21, 32'h00000022, 1'b0, 1'b0, r, f);
    rd_word(d);
    check_eq("hold_rd1", 64'(d), 64'h11);
    @(negedge clk);
    RX_ADDR = 8'h3C; RX_DATA = 32'h99; RX_PEND = 1'b0; RX_BROADCAST = 1'b0; RX_REQ = 1'b1;
    seen = 1'b0;
    repeat (6) begin @(posedge clk); #1; if (RX_ACK) seen = 1'b1; end
    check_eq("hold_no_ack", 64'(seen), 64'd0);
    @(negedge clk); MSG_CLR = 1'b1; RD_EN = 1'b1;
    @(posedge clk); #1; MSG_CLR = 1'b0; RD_EN = 1'b0;
    check_eq("clr_rd_hold_data", 64'(RD_DATA), 64'h11);
    check_eq("clr_rd_empty", 64'(RD_EMPTY), 64'd1);
    check_eq("clr_rd_valid", 64'(MSG_VALID), 64'd0);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!RX_ACK && n < 20);
    check_eq("held_req_ack_lat", 64'(n), 64'd1);
    @(negedge clk); RX_REQ = 1'b0;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (RX_ACK && n < 20);
    check_eq("held_req_valid", 64'(MSG_VALID), 64'd1);
    check_eq("held_req_len", 64'(MSG_LEN), 64'd1);
    check_eq("held_req_addr", 64'(MSG_ADDR), 64'h3C);
    rd_word(d);
    check_eq("held_req_rd", 64'(d), 64'h99);
    msg_clear();

    // Abort counter saturation (one abort already counted)
    for (int i = 0; i < 99; i++) pulse_fail();
    repeat (3) @(negedge clk);
    check_eq("fail_cnt100", 64'(FAIL_CNT), 64'd100);
    for (int i = 0; i < 200; i++) pulse_fail();
    repeat (3) @(negedge clk);
    check_eq("fail_cnt_sat", 64'(FAIL_CNT), 64'd255);

    // Asynchronous reset while RX_ACK is high
    @(negedge clk);
    RX_ADDR = 8'h5A; RX_DATA = 32'hCAFE; RX_PEND = 1'b1; RX_REQ = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!RX_ACK && n < 20);
    check_eq("prerst_ack", 64'(RX_ACK), 64'd1);
    check_eq("prerst_not_empty", 64'(RD_EMPTY), 64'd0);
    #2 RESETn = 1'b0;
    #1;
    check_reset_vals("async_rst");
    RX_REQ = 1'b0;
    repeat (2) @(negedge clk);
    RESETn = 1'b1;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
